// File: rtl/mcpu_stage_ctrl_if.sv
// Control bundle between the multi-cycle stage sequencer and the MIPS datapath/memories.
// master = sequencer side, slave = datapath side.
interface mcpu_stage_ctrl_if;
  logic        stall_req;
  logic        instr_ready;
  logic        mem_ready;
  logic        is_load;
  logic        is_store;
  logic        is_branch;
  logic        is_jump;
  logic        is_jal;
  logic        is_halt;
  logic        regwrite_dec;
  logic        branch_taken;
  logic        ovf_check;
  logic        Overflow;

  logic        IF_signal;
  logic        ID_signal;
  logic        EX_signal;
  logic        MEM_signal;
  logic        WB_signal;
  logic        mem_req;
  logic        ir_write;
  logic        pc_write;
  logic        reg_write;
  logic [1:0]  pc_sel;
  logic        epc_write;
  logic        halted;
  logic        bus_err;
  logic [2:0]  state;
  logic [31:0] retired;

  modport master (
    input  stall_req, instr_ready, mem_ready,
    input  is_load, is_store, is_branch, is_jump, is_jal, is_halt,
    input  regwrite_dec, branch_taken, ovf_check, Overflow,
    output IF_signal, ID_signal, EX_signal, MEM_signal, WB_signal,
    output mem_req, ir_write, pc_write, reg_write, pc_sel, epc_write,
    output halted, bus_err, state, retired
  );

  modport slave (
    output stall_req, instr_ready, mem_ready,
    output is_load, is_store, is_branch, is_jump, is_jal, is_halt,
    output regwrite_dec, branch_taken, ovf_check, Overflow,
    input  IF_signal, ID_signal, EX_signal, MEM_signal, WB_signal,
    input  mem_req, ir_write, pc_write, reg_write, pc_sel, epc_write,
    input  halted, bus_err, state, retired
  );
endinterface

// File: rtl/mcpu_stage_ctrl.sv
// Multi-cycle IF/ID/EX/MEM/WB sequencer with memory timeout, halt and retired counter.
// Define OVERFLOW_TRAP_EN to trap signed ALU overflow in EX (TRAP state, EPC capture).
module mcpu_stage_ctrl #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 4
) (
  input  logic              clk,
  input  logic              rst,
  mcpu_stage_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    ST_IF   = 3'd0,
    ST_ID   = 3'd1,
    ST_EX   = 3'd2,
    ST_MEM  = 3'd3,
    ST_WB   = 3'd4,
    ST_HALT = 3'd5,
    ST_ERR  = 3'd6,
    ST_TRAP = 3'd7
  } state_e;

  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(MEM_TIMEOUT);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      retired_q, retired_d;

  logic       if_en, id_en, ex_en, mem_en, wb_en;
  logic       mem_req, ir_wr, pc_wr, reg_wr, epc_wr;
  logic [1:0] pc_sel;
  logic       stallable;
  logic       completes;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IF;
      cnt_q     <= '0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      retired_q <= retired_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    retired_d = retired_q;
    if_en     = 1'b0;
    id_en     = 1'b0;
    ex_en     = 1'b0;
    mem_en    = 1'b0;
    wb_en     = 1'b0;
    mem_req   = 1'b0;
    ir_wr     = 1'b0;
    pc_wr     = 1'b0;
    reg_wr    = 1'b0;
    epc_wr    = 1'b0;
    pc_sel    = 2'd0;
    stallable = 1'b0;
    completes = 1'b0;

    case (state_q)
      ST_IF: begin
        if_en     = 1'b1;
        mem_req   = 1'b1;
        stallable = 1'b1;
        if (bus.instr_ready) begin
          ir_wr   = 1'b1;
          pc_wr   = 1'b1;
          state_d = ST_ID;
        end else if (cnt_q == TIMEOUT_CNT) begin
          state_d = ST_ERR;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_ID: begin
        id_en     = 1'b1;
        stallable = 1'b1;
        if (bus.is_halt) begin
          state_d = ST_HALT;
        end else if (bus.is_jump) begin
          pc_wr   = 1'b1;
          pc_sel  = 2'd2;
          state_d = bus.is_jal ? ST_WB : ST_IF;
        end else begin
          state_d = ST_EX;
        end
      end
      ST_EX: begin
        ex_en     = 1'b1;
        stallable = 1'b1;
        if (bus.is_branch) begin
          pc_sel  = 2'd1;
          pc_wr   = bus.branch_taken;
          state_d = ST_IF;
        end else if (bus.is_load || bus.is_store) begin
          state_d = ST_MEM;
        end else if (bus.regwrite_dec) begin
`ifdef OVERFLOW_TRAP_EN
          state_d = (bus.ovf_check && bus.Overflow) ? ST_TRAP : ST_WB;
`else
          state_d = ST_WB;
`endif
        end else begin
          state_d = ST_IF;
        end
      end
      ST_MEM: begin
        // stall_req deliberately has no effect here: the bus transaction is already in flight
        mem_en  = 1'b1;
        mem_req = 1'b1;
        if (bus.mem_ready) begin
          state_d = bus.is_load ? ST_WB : ST_IF;
        end else if (cnt_q == TIMEOUT_CNT) begin
          state_d = ST_ERR;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_WB: begin
        wb_en     = 1'b1;
        reg_wr    = 1'b1;
        stallable = 1'b1;
        state_d   = ST_IF;
      end
      ST_HALT: begin
        state_d = ST_HALT;
      end
      ST_ERR: begin
        state_d = ST_ERR;
      end
`ifdef OVERFLOW_TRAP_EN
      ST_TRAP: begin
        epc_wr  = 1'b1;
        pc_wr   = 1'b1;
        pc_sel  = 2'd3;
        state_d = ST_IF;
      end
`endif
      default: begin
        state_d = ST_IF;
      end
    endcase

    // A stall holds the stage (and the fetch wait counter) and drops every write strobe.
    if (bus.stall_req && stallable) begin
      state_d = state_q;
      cnt_d   = cnt_q;
      ir_wr   = 1'b0;
      pc_wr   = 1'b0;
      reg_wr  = 1'b0;
    end

    if (state_d != state_q) begin
      cnt_d = '0;
    end

    completes = (state_d == ST_IF) &&
                (state_q inside {ST_ID, ST_EX, ST_MEM, ST_WB, ST_TRAP});
    if (completes) begin
      retired_d = retired_q + 32'd1;
    end
  end

`ifndef OVERFLOW_TRAP_EN
  logic unused_ovf;
  assign unused_ovf = bus.ovf_check ^ bus.Overflow;
`endif

  assign bus.IF_signal  = if_en  & ~rst;
  assign bus.ID_signal  = id_en  & ~rst;
  assign bus.EX_signal  = ex_en  & ~rst;
  assign bus.MEM_signal = mem_en & ~rst;
  assign bus.WB_signal  = wb_en  & ~rst;
  assign bus.mem_req    = mem_req & ~rst;
  assign bus.ir_write   = ir_wr  & ~rst;
  assign bus.pc_write   = pc_wr  & ~rst;
  assign bus.reg_write  = reg_wr & ~rst;
  assign bus.epc_write  = epc_wr & ~rst;
  assign bus.pc_sel     = rst ? 2'd0 : pc_sel;
  assign bus.halted     = ~rst & (state_q == ST_HALT);
  assign bus.bus_err    = ~rst & (state_q == ST_ERR);
  assign bus.state      = rst ? 3'd0 : state_q;
  assign bus.retired    = rst ? 32'd0 : retired_q;

  stage_onehot_a: assert property (@(posedge clk) disable iff (rst)
    $onehot0({if_en, id_en, ex_en, mem_en, wb_en}));

  stopped_quiet_a: assert property (@(posedge clk) disable iff (rst)
    (state_q inside {ST_HALT, ST_ERR}) |-> !(ir_wr || pc_wr || reg_wr || mem_req || epc_wr));

endmodule

// File: tb/tb_mcpu_stage_ctrl.sv
// Randomized instruction-level bench for mcpu_stage_ctrl: each instruction is expanded into its
// expected per-cycle stage/strobe trace from the sequencing rules and compared cycle by cycle.
module tb_mcpu_stage_ctrl;

  logic clk = 1'b0;
  logic rst;

  mcpu_stage_ctrl_if bus ();

  mcpu_stage_ctrl #(
    .MEM_TIMEOUT (15),
    .CNT_W       (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  localparam int TIMEOUT = 15;

  localparam int K_ALU   = 0;
  localparam int K_NOP   = 1;
  localparam int K_LOAD  = 2;
  localparam int K_STORE = 3;
  localparam int K_BR    = 4;
  localparam int K_J     = 5;
  localparam int K_JAL   = 6;
  localparam int K_OVF   = 7;
  localparam int K_HALT  = 8;

  // expected-strobe bit positions
  localparam logic [11:0] S_IF   = 12'h800;
  localparam logic [11:0] S_ID   = 12'h400;
  localparam logic [11:0] S_EX   = 12'h200;
  localparam logic [11:0] S_MEM  = 12'h100;
  localparam logic [11:0] S_WB   = 12'h080;
  localparam logic [11:0] S_REQ  = 12'h040;
  localparam logic [11:0] S_IRW  = 12'h020;
  localparam logic [11:0] S_PCW  = 12'h010;
  localparam logic [11:0] S_RW   = 12'h008;
  localparam logic [11:0] S_EPC  = 12'h004;
  localparam logic [11:0] S_HLT  = 12'h002;
  localparam logic [11:0] S_BERR = 12'h001;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_ret;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] obs_vec();
    return {bus.IF_signal, bus.ID_signal, bus.EX_signal, bus.MEM_signal, bus.WB_signal,
            bus.mem_req, bus.ir_write, bus.pc_write, bus.reg_write, bus.epc_write,
            bus.halted, bus.bus_err};
  endfunction

  // Inputs for this cycle are already driven; compare, then move to the next falling edge.
  task automatic cyc(input string tag, input logic [2:0] st, input logic [11:0] sv,
                     input logic [1:0] sel);
    #1;
    check_eq({tag, ".state"}, 32'(bus.state), 32'(st));
    check_eq({tag, ".strobes"}, 32'(obs_vec()), 32'(sv));
    check_eq({tag, ".pc_sel"}, 32'(bus.pc_sel), 32'(sel));
    check_eq({tag, ".retired"}, bus.retired, exp_ret);
    @(negedge clk);
  endtask

  task automatic clr_in();
    bus.stall_req    = 1'b0;
    bus.instr_ready  = 1'b0;
    bus.mem_ready    = 1'b0;
    bus.is_load      = 1'b0;
    bus.is_store     = 1'b0;
    bus.is_branch    = 1'b0;
    bus.is_jump      = 1'b0;
    bus.is_jal       = 1'b0;
    bus.is_halt      = 1'b0;
    bus.regwrite_dec = 1'b0;
    bus.branch_taken = 1'b0;
    bus.ovf_check    = 1'b0;
    bus.Overflow     = 1'b0;
  endtask

  task automatic set_dec(input int k, input bit taken);
    bus.is_load      = (k == K_LOAD);
    bus.is_store     = (k == K_STORE);
    bus.is_branch    = (k == K_BR);
    bus.is_jump      = (k == K_J) || (k == K_JAL);
    bus.is_jal       = (k == K_JAL);
    bus.is_halt      = (k == K_HALT);
    bus.regwrite_dec = (k == K_ALU) || (k == K_LOAD) || (k == K_JAL) || (k == K_OVF);
    bus.branch_taken = taken;
    bus.ovf_check    = (k == K_OVF);
    bus.Overflow     = (k == K_OVF) ? 1'b1 : 1'($urandom_range(0, 1));
  endtask

  task automatic do_reset();
    rst             = 1'b1;
    bus.instr_ready = 1'($urandom_range(0, 1));
    bus.mem_ready   = 1'($urandom_range(0, 1));
    bus.stall_req   = 1'($urandom_range(0, 1));
    exp_ret         = 32'd0;
    cyc("rst0", 3'd0, 12'h000, 2'd0);
    cyc("rst1", 3'd0, 12'h000, 2'd0);
    rst = 1'b0;
    clr_in();
  endtask

  task automatic ph_wb(input int swb);
    for (int i = 0; i < swb; i++) begin
      bus.stall_req = 1'b1;
      cyc("wb_stall", 3'd4, S_WB, 2'd0);
    end
    bus.stall_req = 1'b0;
    cyc("wb", 3'd4, S_WB | S_RW, 2'd0);
    exp_ret++;
  endtask

  // Runs one instruction from its first IF cycle. Delays of 16 or more model a ready that never comes.
  task automatic run_instr(input int k, input int fdelay, input bit fstall, input int sid,
                           input int sex, input int swb, input int mdelay, input bit taken);
    set_dec(k, taken);
    for (int i = 0; i < fdelay && i <= TIMEOUT; i++) begin
      bus.instr_ready = 1'b0;
      bus.stall_req   = (fdelay > TIMEOUT) ? 1'b0 : 1'($urandom_range(0, 1));
      cyc("if_wait", 3'd0, S_IF | S_REQ, 2'd0);
    end
    if (fdelay > TIMEOUT) begin
      bus.stall_req = 1'($urandom_range(0, 1));
      cyc("if_err", 3'd6, S_BERR, 2'd0);
      cyc("if_err_sticky", 3'd6, S_BERR, 2'd0);
      return;
    end
    if (fstall) begin
      bus.instr_ready = 1'b1;
      bus.stall_req   = 1'b1;
      cyc("if_stall", 3'd0, S_IF | S_REQ, 2'd0);
    end
    bus.instr_ready = 1'b1;
    bus.stall_req   = 1'b0;
    cyc("if_take", 3'd0, S_IF | S_REQ | S_IRW | S_PCW, 2'd0);
    bus.instr_ready = 1'b0;

    for (int i = 0; i < sid; i++) begin
      bus.stall_req = 1'b1;
      cyc("id_stall", 3'd1, S_ID, bus.is_jump ? 2'd2 : 2'd0);
    end
    bus.stall_req = 1'b0;
    if (k == K_HALT) begin
      cyc("id_halt", 3'd1, S_ID, 2'd0);
      for (int i = 0; i < 3; i++) begin
        bus.stall_req   = 1'($urandom_range(0, 1));
        bus.instr_ready = 1'($urandom_range(0, 1));
        cyc("halt", 3'd5, S_HLT, 2'd0);
      end
      return;
    end
    if (k == K_J || k == K_JAL) begin
      cyc("id_jump", 3'd1, S_ID | S_PCW, 2'd2);
      if (k == K_JAL) ph_wb(swb);
      else exp_ret++;
      return;
    end
    cyc("id", 3'd1, S_ID, 2'd0);

    for (int i = 0; i < sex; i++) begin
      bus.stall_req = 1'b1;
      cyc("ex_stall", 3'd2, S_EX, (k == K_BR) ? 2'd1 : 2'd0);
    end
    bus.stall_req = 1'b0;
    if (k == K_BR) begin
      cyc("ex_branch", 3'd2, S_EX | (taken ? S_PCW : 12'h000), 2'd1);
      exp_ret++;
      return;
    end
    cyc("ex", 3'd2, S_EX, 2'd0);

    if (k == K_LOAD || k == K_STORE) begin
      for (int i = 0; i < mdelay && i <= TIMEOUT; i++) begin
        bus.mem_ready = 1'b0;
        bus.stall_req = 1'($urandom_range(0, 1));
        cyc("mem_wait", 3'd3, S_MEM | S_REQ, 2'd0);
      end
      if (mdelay > TIMEOUT) begin
        bus.stall_req = 1'($urandom_range(0, 1));
        cyc("mem_err", 3'd6, S_BERR, 2'd0);
        bus.mem_ready = 1'b1;
        cyc("mem_err_sticky", 3'd6, S_BERR, 2'd0);
        bus.mem_ready = 1'b0;
        return;
      end
      bus.mem_ready = 1'b1;
      bus.stall_req = 1'($urandom_range(0, 1));
      cyc("mem_done", 3'd3, S_MEM | S_REQ, 2'd0);
      bus.mem_ready = 1'b0;
      if (k == K_LOAD) ph_wb(swb);
      else exp_ret++;
    end else if (bus.regwrite_dec) begin
`ifdef OVERFLOW_TRAP_EN
      if (k == K_OVF) begin
        bus.stall_req = 1'($urandom_range(0, 1));
        cyc("trap", 3'd7, S_PCW | S_EPC, 2'd3);
        exp_ret++;
        return;
      end
`endif
      ph_wb(swb);
    end else begin
      exp_ret++;
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    rst = 1'b1;
    clr_in();
    exp_ret = 32'd0;
    @(negedge clk);
    do_reset();

    run_instr(K_ALU,   1, 0, 0, 0, 0, 0, 0);
    run_instr(K_LOAD,  0, 0, 0, 0, 0, 2, 0);
    run_instr(K_BR,    0, 0, 0, 0, 0, 0, 1);
    run_instr(K_BR,    2, 0, 0, 0, 0, 0, 0);
    run_instr(K_JAL,   0, 0, 1, 0, 1, 0, 0);
    run_instr(K_J,     0, 1, 0, 0, 0, 0, 0);
    run_instr(K_ALU,   0, 0, 0, 2, 0, 0, 0);
    run_instr(K_OVF,   0, 0, 0, 0, 0, 0, 0);
    run_instr(K_NOP,   0, 0, 0, 0, 0, 0, 0);
    run_instr(K_STORE, 0, 0, 0, 0, 0, 15, 0);
    run_instr(K_LOAD,  15, 0, 0, 0, 0, 0, 0);

    // abort a load in its MEM stage
    set_dec(K_LOAD, 0);
    bus.instr_ready = 1'b1;
    cyc("abort_if", 3'd0, S_IF | S_REQ | S_IRW | S_PCW, 2'd0);
    bus.instr_ready = 1'b0;
    cyc("abort_id", 3'd1, S_ID, 2'd0);
    cyc("abort_ex", 3'd2, S_EX, 2'd0);
    cyc("abort_mem", 3'd3, S_MEM | S_REQ, 2'd0);
    do_reset();
    cyc("post_rst", 3'd0, S_IF | S_REQ, 2'd0);

    run_instr(K_STORE, 0, 0, 0, 0, 0, 16, 0);
    do_reset();
    run_instr(K_ALU, 16, 0, 0, 0, 0, 0, 0);
    do_reset();
    run_instr(K_HALT, 0, 0, 1, 0, 0, 0, 0);
    do_reset();

    for (int n = 0; n < 150; n++) begin
      k = $urandom_range(K_ALU, K_OVF);
      run_instr(k, $urandom_range(0, 5), 1'($urandom_range(0, 3) == 0),
                $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2),
                $urandom_range(0, 6), 1'($urandom_range(0, 1)));
    end
    run_instr(K_HALT, 1, 0, 0, 0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
